// File: rtl/onewire_rom_reader.sv
// 1-Wire bus master: reset/presence, one ROM command byte, then N_BYTES read LSB first.
// Define ONEWIRE_CRC_EN to check the received bits with the Dallas CRC-8 (err_crc).
module onewire_rom_reader #(
  parameter int         CLK_FREQ_HZ = 100000000,
  parameter int         N_BYTES     = 8,
  parameter logic [7:0] ROM_CMD     = 8'h33,
  parameter int         T_RSTL_US   = 630,
  parameter int         T_PDW_US    = 240,
  parameter int         T_SLOT_US   = 70,
  parameter int         T_W0L_US    = 60,
  parameter int         T_W1L_US    = 6,
  parameter int         T_RDS_US    = 15,
  parameter int         T_REC_US    = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic                   dq_in,
  output logic                   dq_oe,
  output logic                   busy,
  output logic                   done,
  output logic                   err_nopres,
  output logic                   err_crc,
  output logic [8*N_BYTES-1:0]   result
);

  localparam int DIV   = CLK_FREQ_HZ / 1000000;
  localparam int DW    = $clog2(DIV);
  localparam int NBITS = 8 * N_BYTES;
  localparam int BW    = $clog2(NBITS);
  localparam int TW    = 16;

  typedef enum logic [2:0] {IDLE, RST_LOW, PRES, CMD, READ, CHECK, FIN} state_t;

  state_t           state, state_next;
  logic [DW-1:0]    div_cnt;
  logic             tick;
  logic             dq_meta, dq_sync;
  logic [TW-1:0]    us_cnt, limit;
  logic [BW-1:0]    bit_cnt;
  logic             timed, phase_end, last_bit, pres_hit, sample_pt;
  logic             pres_flag;
  logic [NBITS-1:0] shift;

  // Free-running microsecond tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_cnt <= '0;
    else if (div_cnt == DW'(DIV - 1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end
  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dq_meta <= 1'b1;
      dq_sync <= 1'b1;
    end else begin
      dq_meta <= dq_in;
      dq_sync <= dq_meta;
    end
  end

  always_comb begin
    limit = '0;
    case (state)
      RST_LOW:   limit = TW'(T_RSTL_US - 1);
      PRES:      limit = TW'(T_PDW_US - 1);
      CMD, READ: limit = TW'(T_SLOT_US + T_REC_US - 1);
      default:   limit = '0;
    endcase
  end

  assign timed     = (state == RST_LOW) || (state == PRES) || (state == CMD) || (state == READ);
  assign phase_end = timed && tick && (us_cnt == limit);
  assign last_bit  = (state == CMD) ? (bit_cnt == BW'(7)) : (bit_cnt == BW'(NBITS - 1));
  // Skip the first two ticks of the window so the master's own release edge is never mistaken for presence
  assign pres_hit  = (state == PRES) && tick && (us_cnt >= TW'(2)) && !dq_sync;
  assign sample_pt = (state == READ) && tick && (us_cnt == TW'(T_RDS_US - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = RST_LOW;
      RST_LOW: if (phase_end) state_next = PRES;
      PRES:    if (phase_end) state_next = (pres_flag || pres_hit) ? CMD : FIN;
      CMD:     if (phase_end && last_bit) state_next = READ;
      READ:    if (phase_end && last_bit) state_next = CHECK;
      CHECK:   state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dq_oe = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      RST_LOW: dq_oe = 1'b1;
      CMD:     dq_oe = ROM_CMD[bit_cnt[2:0]] ? (us_cnt < TW'(T_W1L_US)) : (us_cnt < TW'(T_W0L_US));
      READ:    dq_oe = (us_cnt < TW'(T_W1L_US));
      FIN: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      us_cnt     <= '0;
      bit_cnt    <= '0;
      pres_flag  <= 1'b0;
      err_nopres <= 1'b0;
      shift      <= '0;
      result     <= '0;
    end else begin
      if (phase_end || !timed)
        us_cnt <= '0;
      else if (tick)
        us_cnt <= us_cnt + 1'b1;

      if ((state == CMD || state == READ) && phase_end)
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;

      if (state == IDLE && go) begin
        pres_flag  <= 1'b0;
        err_nopres <= 1'b0;
      end else begin
        if (pres_hit)
          pres_flag <= 1'b1;
        if (state == PRES && phase_end && !(pres_flag || pres_hit))
          err_nopres <= 1'b1;
      end

      if (sample_pt)
        shift <= {dq_sync, shift[NBITS-1:1]};

      if (state == CHECK)
        result <= shift;
    end
  end

`ifdef ONEWIRE_CRC_EN
  logic [7:0] crc;
  logic       crc_fb;

  // Reflected x^8+x^5+x^4+1; a valid frame including its CRC byte leaves zero
  assign crc_fb = crc[0] ^ dq_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc     <= '0;
      err_crc <= 1'b0;
    end else begin
      if (state == IDLE && go) begin
        crc     <= '0;
        err_crc <= 1'b0;
      end else if (sample_pt) begin
        crc <= {1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
      end
      if (state == CHECK)
        err_crc <= (crc != 8'h00);
    end
  end
`else
  assign err_crc = 1'b0;
`endif

endmodule

// File: doc/onewire_rom_reader.md
Name: onewire_rom_reader

Overview:
- Parametrised 1-Wire bus master. Issues reset/presence, sends a ROM command byte, then reads N_BYTES back, LSB first.
- Serves DS2411 serial-number chips and any 1-Wire device on one open-drain line.
- Runs entirely on the system clock with a clock-enable microsecond tick. No derived clocks and no blocking delays.
- The result is checked with the Dallas CRC-8 when the optional CRC feature is compiled in.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency. The tick divider is CLK_FREQ_HZ/1000000 and must be an integer of at least 2.
- N_BYTES, 8, number of bytes read after the command (1..16).
- ROM_CMD, 8'h33, command byte sent after presence (READ ROM).
- T_RSTL_US, 630, reset low time.
- T_PDW_US, 240, presence window after release.
- T_SLOT_US, 70, total write/read slot length.
- T_W0L_US, 60, low time for writing a 0.
- T_W1L_US, 6, low time for writing a 1 and for a read-slot initiation.
- T_RDS_US, 15, read sample point, measured from slot start.
- T_REC_US, 10, recovery (released) time between slots.

Ports:
- clk  in  1  100 MHz system master clock.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  single-cycle start pulse. Ignored while busy=1.
- dq_in  in  1  bus level read back from the pad. Asynchronous.
- dq_oe  out  1  1 drives the bus low (pad: dq = dq_oe ? 0 : z). Never drives high.
- busy  out  1  high from the cycle after an accepted go until done/error.
- done  out  1  one-cycle pulse at the end of a transaction, success or failure.
- err_nopres  out  1  sticky until the next go: no presence pulse seen.
- err_crc  out  1  sticky until the next go: CRC check failed.
- result  out  8*N_BYTES  received data. Bit i is the i-th bit received.

Behaviour:
- Reset (asynchronous): dq_oe=0, busy=0, done=0, err_nopres=0, err_crc=0, result=0, state=IDLE, all counters=0.
- Reset asserted mid-transaction releases the bus in the same instant. No partial result is retained.
- dq_in passes through a 2-flop synchroniser before use. The 2-cycle lag is negligible against microsecond timing.
- tick: one-clk pulse every CLK_FREQ_HZ/1000000 clocks, free-running. All timers advance only on tick.
- States:
  - IDLE: dq_oe=0. An accepted go clears err_*, sets busy, and moves to RST_LOW. result holds its last value.
  - RST_LOW: dq_oe=1 for T_RSTL_US ticks, then PRES.
  - PRES: dq_oe=0 for T_PDW_US ticks. A synchronised dq_in=0 sampled on any tick after the first 2 ticks sets a presence flag. At window end: flag=1 goes to CMD; flag=0 sets err_nopres and goes to FIN.
  - CMD: 8 write slots, bit 0 of ROM_CMD first. Each slot drives low for T_W0L_US (bit=0) or T_W1L_US (bit=1), releases for the rest of T_SLOT_US, then holds T_REC_US released. After 8 slots, goes to READ.
  - READ: 8*N_BYTES read slots. Each drives low T_W1L_US, releases, samples synchronised dq_in on tick T_RDS_US, completes T_SLOT_US, then holds T_REC_US. Samples shift into an internal register LSB-first.
  - CHECK: one clk. Copies the shift register to result and evaluates the CRC, then goes to FIN.
  - FIN: one clk. done=1 and busy=0 on the same cycle, then IDLE.
- result updates only in CHECK. A failed presence leaves result unchanged.
- A go coincident with FIN, or arriving while busy=1, is ignored.
- Slot counters are wide enough for 8*N_BYTES. No wrap-around is possible within a transaction.
- Duration at defaults: (630+240) + 8*80 + 64*80 us, about 6.63 ms, plus at most one tick of alignment latency after go.

Optional Feature:
- Macro: ONEWIRE_CRC_EN.
- Defined: a serial CRC-8 (x^8+x^5+x^4+1, reflected, init 0) runs over every received bit during READ. A nonzero remainder at CHECK sets err_crc. result is still updated.
- Undefined: no CRC logic. err_crc is tied to 0.

Test Plan:
- Bench: 1-Wire device model on the open-drain bus with pull-up, CLK_FREQ_HZ=100000000, defaults otherwise.
- Model ROM bytes 02,1C,B8,01,00,00,00,A2 -> the model sees command 0x33 LSB-first; result=64'hA2000000_01B81C02; err_nopres=0; err_crc=0; done pulses once; busy high for ~6.63 ms.
- No device attached (bus stays high) -> err_nopres=1; done pulses about 870 us after go; no CMD slots driven; result keeps its prior value.
- Model CRC byte corrupted to A3 -> result=64'hA3000000_01B81C02; err_crc=1 with ONEWIRE_CRC_EN, 0 without.
- reset pulsed 100 us into RST_LOW -> dq_oe=0 immediately; busy=0; result=0; a following go completes normally.
- go re-pulsed while busy, and go coincident with FIN -> both ignored; exactly one done pulse per accepted go.
- N_BYTES=2, ROM_CMD=8'hCC -> 8 write slots plus 16 read slots; result[15:0] equals the model's first two bytes.
